rm_symbol_encoder: RTL and testbench
====================================

Name: rm_symbol_encoder

Overview:
- Producer side of the runtime-monitor symbol stream. Converts per-cycle core event vectors from CVA6 into the serial 8-bit symbol and run stream consumed by each monitor cluster top.
- Buffers bursts of events in a small FIFO and emits one symbol per cycle, lowest event index first.
- Each vector is optionally followed by a separator symbol.
- Reports overflow when events arrive faster than they can be serialized.

Parameters:
- NUM_EVENTS, 16: width of the event vector; event i encodes to symbol SYM_BASE+i.
- DEPTH, 4: FIFO depth in vectors; must be a power of 2 and at least 2.
- SYM_BASE, 8'h01: symbol code of event 0. Constraint: SYM_BASE+NUM_EVENTS-1 <= 8'hFE.
- SEP_SYM, 8'hFF: end-of-vector separator symbol.
- EMIT_SEP, 1: 1 = emit SEP_SYM after each vector; 0 = no separator.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  serializer advance enable; the FIFO still accepts input when low.
- event_valid  in  1  events is valid this cycle.
- events  in  NUM_EVENTS  one-hot-or-multi event flags.
- clear_ovf  in  1  clears overflow and drop_count.
- symbols  out  8  symbol to monitor (drives its symbols input).
- run  out  1  symbols valid this cycle (drives monitor run).
- busy  out  1  FIFO non-empty or state != IDLE.
- overflow  out  1  sticky: a nonzero vector was dropped.
- drop_count  out  8  saturating count of dropped vectors.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. Clears symbols=0, run=0, overflow=0, drop_count=0, FIFO empty, state=IDLE.
- Reset mid-emission: the current vector and all queued vectors are discarded. run=0 from the cycle after reset is sampled.
- Push: occurs when event_valid=1 and events!=0.
  - events==0 is ignored: no push, no drop.
  - If the FIFO is full and no pop happens that edge, the vector is dropped: overflow<=1, drop_count<=min(drop_count+1,255).
  - If full and a pop happens on the same edge, the push is accepted.
- clear_ovf=1 clears overflow and drop_count. A simultaneous drop on the same edge wins: overflow=1, drop_count=1.
- Serializer state machine (outputs registered):
  - IDLE: run<=0, symbols<=0. If enable and FIFO non-empty: pop into cur_vec, go to EMIT.
  - EMIT: if enable, symbols<=SYM_BASE+k (k = lowest set bit of cur_vec), run<=1, clear bit k.
    - If k was the last set bit: if EMIT_SEP go to SEP; else if FIFO non-empty, pop and stay in EMIT (no bubble); else go to IDLE.
  - SEP: if enable, symbols<=SEP_SYM, run<=1. Then if FIFO non-empty, pop into cur_vec and go to EMIT; else go to IDLE.
  - enable=0 in any state: run<=0, symbols<=0, state and cur_vec held.
- Latency: a vector presented in cycle c (FIFO empty, idle, enable=1) produces its first run=1 in cycle c+3.
- Steady state: exactly popcount(vector)+EMIT_SEP run cycles per vector, with no idle cycles between queued vectors.
- Symbol ordering: within a vector, ascending event index. Across vectors, FIFO order.
- Arithmetic: symbols = SYM_BASE + k, computed at 8 bits; the parameter constraint guarantees no wrap.
- busy is combinational from FIFO empty and state.

Decomposition:
- Package rm_sym_pkg holds:
  - SYM_W=8
  - default SEP_SYM
  - enc_state_t enum {IDLE, EMIT, SEP}
  - a lowest-set-bit function
- One sub-module, rm_event_fifo:
  - synchronous FIFO, width NUM_EVENTS, depth DEPTH
  - ports: push/pop, full/empty
  - read data valid combinationally while not empty
  - same-edge push-on-full-with-pop supported

Test Plan:
- Reset: assert reset 2 cycles with event_valid=1, events=16'hFFFF -> run=0, symbols=0, overflow=0, busy=0 after release; no symbols emitted.
- Single vector: events=16'h0005 in cycle 0 -> run=1 in cycles 3, 4, 5 with symbols 8'h01, 8'h03, 8'hFF; run=0 in cycle 6.
- Back-to-back: 16'h0001 in cycle 0, 16'h8000 in cycle 1 -> contiguous run=1 cycles with symbols 01, FF, 10, FF; no bubble.
- Overflow and full+pop:
  - With enable=0, push 5 nonzero vectors -> 5th dropped, overflow=1, drop_count=1.
  - Set enable=1 and push one vector on the same edge as the first pop -> that vector is accepted.
  - All 5 accepted vectors drain in order.
  - clear_ovf -> overflow=0, drop_count=0.
- Zero vector plus saturation:
  - event_valid=1, events=0 -> no push, busy stays 0.
  - Force 300 drops -> drop_count=255.
- Reset mid-operation: 16'hFFFF in cycle 0, reset in cycle 6 -> run=0 from cycle 7, busy=0, no further symbols.

Source files
------------

// File: rtl/rm_sym_pkg.sv
// rm_sym_pkg: shared types and helpers for the runtime-monitor symbol encoder
package rm_sym_pkg;
  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] SEP_SYM_DEFAULT = 8'hFF;
  typedef enum logic [1:0] {IDLE, EMIT, SEP} enc_state_t;
  function automatic logic [SYM_W-1:0] lowest_set(input logic [255:0] v);
    logic [SYM_W-1:0] r;
    r = '0;
    for (int i = 255; i >= 0; i--) if (v[i]) r = SYM_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/rm_event_fifo.sv
// rm_event_fifo: synchronous vector FIFO that accepts a push on full when a pop shares the edge
module rm_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic do_push, do_pop;
  always_comb begin
    empty_o = wptr_q == rptr_q;
    full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rdata_o = mem_q[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(do_push);
      rptr_q <= rptr_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/rm_symbol_encoder.sv
// rm_symbol_encoder: serializes core event vectors into the monitor symbol/run stream
module rm_symbol_encoder
  import rm_sym_pkg::*;
#(
  parameter int               NUM_EVENTS = 16,
  parameter int               DEPTH      = 4,
  parameter logic [SYM_W-1:0] SYM_BASE   = 8'h01,
  parameter logic [SYM_W-1:0] SEP_SYM    = SEP_SYM_DEFAULT,
  parameter bit               EMIT_SEP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  event_valid,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  clear_ovf,
  output logic [SYM_W-1:0]      symbols,
  output logic                  run,
  output logic                  busy,
  output logic                  overflow,
  output logic [SYM_W-1:0]      drop_count
);
  logic push, pop, drop, full, empty, last;
  logic [NUM_EVENTS-1:0] head, cur_q, cur_rest;
  logic [SYM_W-1:0] sym_q, drop_q;
  logic run_q, ovf_q;
  enc_state_t state_q;
  rm_event_fifo #(.WIDTH(NUM_EVENTS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(push), .wdata_i(events), .pop_i(pop),
    .rdata_o(head), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    cur_rest = cur_q & (cur_q - NUM_EVENTS'(1));
    last     = cur_rest == '0;
    push     = event_valid && |events;
    pop      = enable && !empty && (state_q != EMIT || (last && !EMIT_SEP));
    drop     = push && full && !pop;
    busy     = !empty || state_q != IDLE;
  end
  assign symbols    = sym_q;
  assign run        = run_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      sym_q   <= '0;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      run_q  <= enable && state_q != IDLE;
      sym_q  <= (!enable || state_q == IDLE) ? '0 :
                state_q == SEP ? SEP_SYM : SYM_BASE + lowest_set(256'(cur_q));
      ovf_q  <= drop || (ovf_q && !clear_ovf);
      // a drop on the same edge as clear_ovf restarts the count at one
      drop_q <= drop ? (clear_ovf ? 8'd1 : drop_q == 8'hFF ? drop_q : drop_q + 8'd1) :
                clear_ovf ? '0 : drop_q;
      cur_q  <= pop ? head : (enable && state_q == EMIT) ? cur_rest : cur_q;
      if (enable)
        state_q <= (state_q == EMIT && !last) ? EMIT :
                   (state_q == EMIT && EMIT_SEP) ? SEP :
                   empty ? IDLE : EMIT;
    end
  end
endmodule

// File: tb/tb_rm_symbol_encoder.sv
// tb_rm_symbol_encoder: directed and random checks against a queue-based stream model
module tb_rm_symbol_encoder;
  logic clk = 1'b0;
  logic reset, enable, event_valid, clear_ovf;
  logic [15:0] events;
  logic [7:0] symbols, drop_count;
  logic run, busy, overflow;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rm_symbol_encoder dut (
    .clk(clk), .reset(reset), .enable(enable), .event_valid(event_valid),
    .events(events), .clear_ovf(clear_ovf), .symbols(symbols), .run(run),
    .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  // Model: queue of pending vectors plus queue of symbols left for the loaded vector.
  logic [15:0] m_fifo[$];
  logic [7:0]  m_cur[$];
  logic        m_run, m_ovf, m_pop, m_drop;
  logic [7:0]  m_sym, m_dc;
  bit          m_ok = 0;
  int          m_sz;

  function automatic void m_load();
    logic [15:0] v;
    v = m_fifo.pop_front();
    for (int i = 0; i < 16; i++) if (v[i]) m_cur.push_back(8'h01 + 8'(i));
    m_cur.push_back(8'hFF);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_fifo.delete(); m_cur.delete();
      m_run = 0; m_sym = 0; m_ovf = 0; m_dc = 0; m_ok = 1;
    end else begin
      m_pop = 0; m_drop = 0; m_run = 0; m_sym = 0;
      if (enable) begin
        if (m_cur.size() != 0) begin m_sym = m_cur.pop_front(); m_run = 1; end
        if (m_cur.size() == 0 && m_fifo.size() != 0) begin m_load(); m_pop = 1; end
      end
      m_sz = m_fifo.size() + (m_pop ? 1 : 0);
      if (event_valid && events != 0) begin
        if (m_sz < 4 || m_pop) m_fifo.push_back(events);
        else m_drop = 1;
      end
      if (m_drop) begin
        m_ovf = 1;
        m_dc = clear_ovf ? 8'd1 : (m_dc == 8'hFF ? 8'hFF : m_dc + 8'd1);
      end else if (clear_ovf) begin
        m_ovf = 0; m_dc = 0;
      end
    end
  end

  always @(negedge clk) if (m_ok) begin
    checks++;
    if (run !== m_run || symbols !== m_sym || overflow !== m_ovf || drop_count !== m_dc ||
        busy !== (m_fifo.size() != 0 || m_cur.size() != 0)) begin
      errors++;
      $display("FAIL model t=%0t got run=%b sym=%h busy=%b ovf=%b dc=%0d want run=%b sym=%h busy=%b ovf=%b dc=%0d",
               $time, run, symbols, busy, overflow, drop_count, m_run, m_sym,
               (m_fifo.size() != 0 || m_cur.size() != 0), m_ovf, m_dc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk(name, {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] got[$];
  logic [7:0] exp_ovf [10] = '{8'h02, 8'hFF, 8'h03, 8'hFF, 8'h04, 8'hFF, 8'h05, 8'hFF, 8'h07, 8'hFF};
  int nrun;

  initial begin
    reset = 1; enable = 1; event_valid = 1; events = 16'hFFFF; clear_ovf = 0;
    repeat (2) @(negedge clk);
    reset = 0; event_valid = 0; events = 0;
    repeat (2) @(negedge clk);
    chk("reset_out", {run, symbols}, 0);
    chk("reset_ovf", {overflow, drop_count}, 0);
    chk("reset_busy", {31'd0, busy}, 0);

    event_valid = 1; events = 16'h0005;
    @(negedge clk); event_valid = 0; events = 0;
    @(negedge clk); chk("single_c2", {run, symbols}, 9'h000);
    @(negedge clk); chk("single_c3", {run, symbols}, 9'h101);
    @(negedge clk); chk("single_c4", {run, symbols}, 9'h103);
    @(negedge clk); chk("single_c5", {run, symbols}, 9'h1FF);
    @(negedge clk); chk("single_c6", {run, symbols}, 9'h000);
    repeat (2) @(negedge clk);

    event_valid = 1; events = 16'h0001;
    @(negedge clk); events = 16'h8000;
    @(negedge clk); event_valid = 0; events = 0;
    @(negedge clk); chk("b2b_c3", {run, symbols}, 9'h101);
    @(negedge clk); chk("b2b_c4", {run, symbols}, 9'h1FF);
    @(negedge clk); chk("b2b_c5", {run, symbols}, 9'h110);
    @(negedge clk); chk("b2b_c6", {run, symbols}, 9'h1FF);
    @(negedge clk); chk("b2b_c7", {run, symbols}, 9'h000);
    repeat (2) @(negedge clk);

    enable = 0; event_valid = 1;
    for (int i = 0; i < 5; i++) begin events = 16'(1 << (i + 1)); @(negedge clk); end
    chk("ovf_set", {overflow, drop_count}, {1'b1, 8'd1});
    enable = 1; events = 16'h0040;
    got.delete();
    for (int c = 0; c < 80 && got.size() < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        event_valid = 0; events = 0;
        chk("full_pop_push", {overflow, drop_count}, {1'b1, 8'd1});
      end
      if (run) got.push_back(symbols);
    end
    chk("ovf_drain_len", got.size(), 10);
    foreach (got[i]) chk($sformatf("ovf_drain_%0d", i), got[i], exp_ovf[i]);
    drain("ovf_idle");
    clear_ovf = 1;
    @(negedge clk); clear_ovf = 0;
    chk("ovf_clear", {overflow, drop_count}, 0);

    event_valid = 1; events = 0;
    repeat (3) @(negedge clk);
    event_valid = 0;
    chk("zero_vec_busy", {31'd0, busy}, 0);
    chk("zero_vec_ovf", {overflow, drop_count}, 0);

    enable = 0; event_valid = 1;
    for (int i = 0; i < 304; i++) begin events = 16'($urandom_range(1, 65535)); @(negedge clk); end
    event_valid = 0;
    chk("sat_255", {overflow, drop_count}, {1'b1, 8'd255});
    event_valid = 1; events = 16'h0001; clear_ovf = 1;
    @(negedge clk); event_valid = 0;
    chk("clear_vs_drop", {overflow, drop_count}, {1'b1, 8'd1});
    @(negedge clk); clear_ovf = 0;
    chk("clear_after", {overflow, drop_count}, 0);
    enable = 1;
    drain("sat_drain");

    event_valid = 1; events = 16'hFFFF;
    @(negedge clk); event_valid = 0; events = 0;
    repeat (5) @(negedge clk);
    chk("rst_mid_c6", {run, symbols}, 9'h104);
    reset = 1;
    @(negedge clk); reset = 0;
    chk("rst_mid_run", {run, symbols}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    nrun = 0;
    repeat (20) begin @(negedge clk); nrun += run; end
    chk("rst_mid_quiet", nrun, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset       = $urandom_range(0, 499) == 0;
      enable      = $urandom_range(0, 7) != 0;
      event_valid = $urandom_range(0, 2) == 0;
      events      = $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom & $urandom);
      clear_ovf   = $urandom_range(0, 39) == 0;
    end
    @(negedge clk);
    reset = 0; enable = 1; event_valid = 0; events = 0; clear_ovf = 0;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
